// File: rtl/cpu_run_ctrl_if.sv
// Interface between the run controller and its environment: mode and
// step-button inputs, PC / breakpoint compare values, generated CPU clock
// and status outputs.
interface cpu_run_ctrl_if #(
    parameter int PC_W = 32
);
    logic [1:0]      iMode;
    logic            iStepBtn;
    logic [PC_W-1:0] iBreakPC;
    logic [PC_W-1:0] iPC;
    logic            oCpuClk;
    logic            oHalted;
    logic [15:0]     oCycleCnt;
    logic [1:0]      oState;

    // Environment side: drives mode/button/PC, observes clock and status.
    modport master (
        output iMode, iStepBtn, iBreakPC, iPC,
        input  oCpuClk, oHalted, oCycleCnt, oState
    );

    // Controller side.
    modport slave (
        input  iMode, iStepBtn, iBreakPC, iPC,
        output oCpuClk, oHalted, oCycleCnt, oState
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: divides the board clock into the CPU clock
// and decides, once per CPU cycle, whether another cycle is issued.
module cpu_run_ctrl #(
    parameter int DIV_HALF = 10,
    parameter int DEB_CNT  = 4,
    parameter int PC_W     = 32
) (
    input  logic          iClk,
    input  logic          iRst,
    cpu_run_ctrl_if.slave bus
);
    localparam int PH_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int DB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV_HALF - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEB_CNT - 1);

    localparam logic [1:0] M_HALT = 2'b00;
    localparam logic [1:0] M_RUN  = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [1:0] M_RTB  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOW  = 2'b01,
        S_HIGH = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic            sync1_q, sync2_q;
    logic            deb_lvl_q, deb_lvl_d;
    logic            pending_q, pending_d;
    logic            cpu_clk_q, cpu_clk_d;
    logic            halted_q, halted_d;
    logic [15:0]     cycle_cnt_q, cycle_cnt_d;

    logic [PC_W-1:0] pc_s, bp_s;
    logic            press_s, ph_last_s, eval_s, go_s, bp_hit_s, consume_s;

    assign pc_s = bus.iPC;
    assign bp_s = bus.iBreakPC;

    // Button synchronizer and debounced level.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_lvl_q <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= bus.iStepBtn;
            sync2_q   <= sync1_q;
            deb_lvl_q <= deb_lvl_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Debounce: accept a new level after DEB_CNT consecutive mismatching samples.
    always_comb begin
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = '0;
        press_s   = 1'b0;
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DB_LAST) begin
                deb_lvl_d = sync2_q;
                press_s   = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DB_W'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end
    end

    // Decision terms: evaluation point, go, breakpoint hit, step consumption.
    always_comb begin
        ph_last_s = (phase_q == PH_LAST);
        eval_s    = (state_q == S_IDLE) || ((state_q == S_HIGH) && ph_last_s);
        bp_hit_s  = (bus.iMode == M_RTB) && (pc_s == bp_s);
        go_s      = 1'b0;
        consume_s = 1'b0;
        case (bus.iMode)
            M_HALT: go_s = 1'b0;
            M_RUN:  go_s = 1'b1;
            M_STEP: begin
                go_s      = pending_q | press_s;
                consume_s = eval_s & go_s;
            end
            M_RTB:  go_s = (pc_s != bp_s);
            default: go_s = 1'b0;
        endcase
    end

    // Pending step: one deep, dropped outside STEP mode.
    always_comb begin
        if (bus.iMode != M_STEP) begin
            pending_d = 1'b0;
        end else if (consume_s) begin
            pending_d = 1'b0;
        end else if (press_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // FSM state register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a started low/high cycle always runs to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go_s)          state_d = S_LOW;
                else if (bp_hit_s) state_d = S_BRK;
                else               state_d = S_IDLE;
            end
            S_LOW: begin
                if (ph_last_s) state_d = S_HIGH;
                else           state_d = S_LOW;
            end
            S_HIGH: begin
                if (!ph_last_s)    state_d = S_HIGH;
                else if (go_s)     state_d = S_LOW;
                else if (bp_hit_s) state_d = S_BRK;
                else               state_d = S_IDLE;
            end
            S_BRK: begin
                if (bus.iMode == M_RTB) state_d = S_BRK;
                else                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: phase counter, cycle counter and registered clock/halt.
    always_comb begin
        if (((state_q == S_LOW) || (state_q == S_HIGH)) && !ph_last_s) begin
            phase_d = phase_q + PH_W'(1);
        end else begin
            phase_d = '0;
        end
        if ((state_q == S_LOW) && ph_last_s) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
        cpu_clk_d = (state_d == S_HIGH);
        halted_d  = (state_d == S_BRK);
    end

    // Datapath registers; async reset drops the CPU clock immediately.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            phase_q     <= '0;
            cycle_cnt_q <= 16'd0;
            cpu_clk_q   <= 1'b0;
            halted_q    <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cycle_cnt_q <= cycle_cnt_d;
            cpu_clk_q   <= cpu_clk_d;
            halted_q    <= halted_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.oCpuClk   = cpu_clk_q;
    assign bus.oHalted   = halted_q;
    assign bus.oCycleCnt = cycle_cnt_q;
    assign bus.oState    = state_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a DIV_HALF=2 instance checked against
// a timeline model, plus a DIV_HALF=10 instance for pending-step behaviour.
module tb_cpu_run_ctrl;
    localparam int DA = 2;
    localparam int DB = 10;
    localparam logic [1:0] HALT = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STEP = 2'b10;
    localparam logic [1:0] RTB  = 2'b11;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    cpu_run_ctrl_if #(.PC_W(32)) bus_a ();
    cpu_run_ctrl_if #(.PC_W(32)) bus_b ();

    cpu_run_ctrl #(.DIV_HALF(DA), .DEB_CNT(4), .PC_W(32)) dut_a (
        .iClk(iClk), .iRst(iRst), .bus(bus_a)
    );
    cpu_run_ctrl #(.DIV_HALF(DB), .DEB_CNT(4), .PC_W(32)) dut_b (
        .iClk(iClk), .iRst(iRst), .bus(bus_b)
    );

    always #5 iClk = ~iClk;

    // Timeline model of dut_a: position within the current CPU cycle.
    bit          m_busy, m_brk, m_clk;
    int          m_pos;
    logic [15:0] m_cnt;
    logic [31:0] m_pc;

    function automatic logic [1:0] m_state_f();
        if (m_brk)       return 2'b11;
        else if (m_busy) return m_clk ? 2'b10 : 2'b01;
        else             return 2'b00;
    endfunction

    task automatic model_edge(input logic [1:0] mode, input logic [31:0] pc, input logic [31:0] bp);
        if (m_brk) begin
            if (mode != RTB) m_brk = 1'b0;
        end else if (m_busy && (m_pos < 2*DA-1)) begin
            m_pos++;
            if (m_pos == DA) begin
                m_clk = 1'b1;
                m_cnt = m_cnt + 16'd1;
                m_pc  = m_pc + 32'd4;
            end
        end else begin
            m_clk  = 1'b0;
            m_busy = 1'b0;
            m_pos  = 0;
            if ((mode == RUN) || ((mode == RTB) && (pc != bp))) m_busy = 1'b1;
            else if (mode == RTB) m_brk = 1'b1;
        end
    endtask

    task automatic adv();
        model_edge(bus_a.iMode, bus_a.iPC, bus_a.iBreakPC);
        @(posedge iClk);
        @(negedge iClk);
        bus_a.iPC = m_pc;
    endtask

    task automatic do_reset(input logic [1:0] mode_a);
        @(negedge iClk);
        iRst = 1'b1;
        bus_a.iMode = mode_a; bus_a.iStepBtn = 1'b0; bus_a.iPC = 32'd0; bus_a.iBreakPC = 32'd0;
        bus_b.iMode = HALT;   bus_b.iStepBtn = 1'b0; bus_b.iPC = 32'd0; bus_b.iBreakPC = 32'd0;
        m_busy = 1'b0; m_brk = 1'b0; m_clk = 1'b0; m_pos = 0; m_cnt = 16'd0; m_pc = 32'd0;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(HALT);
        iRst = 1'b1;
        #3;
        checks++;
        if ({bus_a.oCpuClk, bus_a.oHalted, bus_a.oCycleCnt, bus_a.oState} !== 20'd0 ||
            {bus_b.oCpuClk, bus_b.oHalted, bus_b.oCycleCnt, bus_b.oState} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs a=%h b=%h expected 0", {bus_a.oCpuClk, bus_a.oHalted, bus_a.oCycleCnt, bus_a.oState},
                     {bus_b.oCpuClk, bus_b.oHalted, bus_b.oCycleCnt, bus_b.oState});
        end
        do_reset(HALT);
        repeat (3) adv();
        checks++;
        if ({bus_a.oCpuClk, bus_a.oHalted, bus_a.oCycleCnt, bus_a.oState} !== 20'd0) begin
            failures++;
            $display("FAIL halt_idle outputs=%h expected 0", {bus_a.oCpuClk, bus_a.oHalted, bus_a.oCycleCnt, bus_a.oState});
        end
    endtask

    task automatic test_run();
        int first_rise = -1;
        int rises = 0;
        logic prev = 1'b0;
        do_reset(RUN);
        for (int i = 0; i < 19; i++) begin
            adv();
            checks++;
            if (bus_a.oCpuClk !== m_clk || bus_a.oCycleCnt !== m_cnt || bus_a.oState !== m_state_f() || bus_a.oHalted !== m_brk) begin
                failures++;
                $display("FAIL run_cycle%0d got clk=%b cnt=%0d st=%0d h=%b want clk=%b cnt=%0d st=%0d h=%b", i,
                         bus_a.oCpuClk, bus_a.oCycleCnt, bus_a.oState, bus_a.oHalted, m_clk, m_cnt, m_state_f(), m_brk);
            end
            if (bus_a.oCpuClk === 1'b1 && prev === 1'b0) begin
                if (first_rise < 0) first_rise = i;
                rises++;
            end
            prev = bus_a.oCpuClk;
        end
        checks++;
        if (first_rise !== 2 || rises !== 5 || bus_a.oCycleCnt !== 16'd5) begin
            failures++;
            $display("FAIL run_start first_rise=%0d rises=%0d cnt=%0d want 2 5 5", first_rise, rises, bus_a.oCycleCnt);
        end
    endtask

    task automatic test_step_debounce();
        int rises1 = 0, highs1 = 0, rises2 = 0;
        logic prev = 1'b0;
        do_reset(STEP);
        for (int i = 0; i < 100; i++) begin
            bus_a.iStepBtn = (i < 2) || (i >= 4 && i < 14) || (i >= 50 && i < 53);
            @(posedge iClk);
            @(negedge iClk);
            if (bus_a.oCpuClk === 1'b1 && prev === 1'b0) begin
                if (i < 50) rises1++; else rises2++;
            end
            if (bus_a.oCpuClk === 1'b1 && i < 50) highs1++;
            prev = bus_a.oCpuClk;
            if (i == 49) begin
                checks++;
                if (rises1 !== 1 || highs1 !== 2 || bus_a.oCycleCnt !== 16'd1) begin
                    failures++;
                    $display("FAIL step_bounce rises=%0d highs=%0d cnt=%0d want 1 2 1", rises1, highs1, bus_a.oCycleCnt);
                end
            end
        end
        checks++;
        if (rises2 !== 0 || bus_a.oCycleCnt !== 16'd1) begin
            failures++;
            $display("FAIL step_glitch rises=%0d cnt=%0d want 0 1", rises2, bus_a.oCycleCnt);
        end
    endtask

    task automatic test_back_to_back();
        int rises = 0, highs = 0;
        int r0 = -1, r1 = -1;
        logic prev = 1'b0;
        do_reset(HALT);
        bus_b.iMode = STEP;
        for (int i = 0; i < 110; i++) begin
            bus_b.iStepBtn = (i < 4) || (i >= 8 && i < 12) || (i >= 16 && i < 20);
            @(posedge iClk);
            @(negedge iClk);
            if (bus_b.oCpuClk === 1'b1 && prev === 1'b0) begin
                if (rises == 0) r0 = i;
                if (rises == 1) r1 = i;
                rises++;
            end
            if (bus_b.oCpuClk === 1'b1) highs++;
            prev = bus_b.oCpuClk;
        end
        checks++;
        if (rises !== 2 || highs !== 2*DB || bus_b.oCycleCnt !== 16'd2) begin
            failures++;
            $display("FAIL step_pending rises=%0d highs=%0d cnt=%0d want 2 %0d 2", rises, highs, bus_b.oCycleCnt, 2*DB);
        end
        checks++;
        if (r1 - r0 !== 2*DB || bus_b.oState !== 2'b00) begin
            failures++;
            $display("FAIL step_gap gap=%0d state=%0d want %0d 0", r1 - r0, bus_b.oState, 2*DB);
        end
    endtask

    task automatic test_breakpoint();
        do_reset(RTB);
        bus_a.iBreakPC = 32'h0000000C;
        for (int i = 0; i < 40; i++) begin
            adv();
            checks++;
            if (bus_a.oCpuClk !== m_clk || bus_a.oCycleCnt !== m_cnt || bus_a.oState !== m_state_f() || bus_a.oHalted !== m_brk) begin
                failures++;
                $display("FAIL bp_cycle%0d got clk=%b cnt=%0d st=%0d h=%b want clk=%b cnt=%0d st=%0d h=%b", i,
                         bus_a.oCpuClk, bus_a.oCycleCnt, bus_a.oState, bus_a.oHalted, m_clk, m_cnt, m_state_f(), m_brk);
            end
        end
        checks++;
        if (bus_a.oCycleCnt !== 16'd3 || bus_a.oHalted !== 1'b1 || bus_a.oState !== 2'b11 || bus_a.oCpuClk !== 1'b0) begin
            failures++;
            $display("FAIL bp_stop cnt=%0d h=%b st=%0d clk=%b want 3 1 3 0", bus_a.oCycleCnt, bus_a.oHalted, bus_a.oState, bus_a.oCpuClk);
        end
        bus_a.iMode = HALT;
        adv();
        checks++;
        if (bus_a.oHalted !== 1'b0 || bus_a.oState !== 2'b00 || bus_a.oCycleCnt !== 16'd3) begin
            failures++;
            $display("FAIL bp_leave h=%b st=%0d cnt=%0d want 0 0 3", bus_a.oHalted, bus_a.oState, bus_a.oCycleCnt);
        end
    endtask

    task automatic test_halt_midcycle();
        int highs = 0;
        do_reset(RUN);
        for (int i = 0; i < 20; i++) begin
            if (i == 6) bus_a.iMode = HALT;
            adv();
            checks++;
            if (bus_a.oCpuClk !== m_clk || bus_a.oCycleCnt !== m_cnt || bus_a.oState !== m_state_f() || bus_a.oHalted !== m_brk) begin
                failures++;
                $display("FAIL halt_cycle%0d got clk=%b cnt=%0d st=%0d h=%b want clk=%b cnt=%0d st=%0d h=%b", i,
                         bus_a.oCpuClk, bus_a.oCycleCnt, bus_a.oState, bus_a.oHalted, m_clk, m_cnt, m_state_f(), m_brk);
            end
            if (i >= 6 && bus_a.oCpuClk === 1'b1) highs++;
        end
        checks++;
        if (highs !== DA || bus_a.oCycleCnt !== 16'd2 || bus_a.oState !== 2'b00) begin
            failures++;
            $display("FAIL halt_complete highs=%0d cnt=%0d st=%0d want %0d 2 0", highs, bus_a.oCycleCnt, bus_a.oState, DA);
        end
    endtask

    task automatic test_wrap_reset();
        do_reset(HALT);
        force dut_a.cycle_cnt_q = 16'hFFFF;
        @(posedge iClk);
        @(negedge iClk);
        release dut_a.cycle_cnt_q;
        m_cnt = 16'hFFFF;
        bus_a.iMode = RUN;
        for (int i = 0; i < 7; i++) begin
            adv();
            checks++;
            if (bus_a.oCpuClk !== m_clk || bus_a.oCycleCnt !== m_cnt || bus_a.oState !== m_state_f()) begin
                failures++;
                $display("FAIL wrap_cycle%0d got clk=%b cnt=%h st=%0d want clk=%b cnt=%h st=%0d", i,
                         bus_a.oCpuClk, bus_a.oCycleCnt, bus_a.oState, m_clk, m_cnt, m_state_f());
            end
            if (i == 2) begin
                checks++;
                if (bus_a.oCycleCnt !== 16'h0000 || bus_a.oCpuClk !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_value cnt=%h clk=%b want 0000 1", bus_a.oCycleCnt, bus_a.oCpuClk);
                end
            end
        end
        #2;
        iRst = 1'b1;
        #1;
        checks++;
        if ({bus_a.oCpuClk, bus_a.oHalted, bus_a.oCycleCnt, bus_a.oState} !== 20'd0) begin
            failures++;
            $display("FAIL async_reset outputs=%h expected 0", {bus_a.oCpuClk, bus_a.oHalted, bus_a.oCycleCnt, bus_a.oState});
        end
        @(negedge iClk);
        iRst = 1'b0;
    endtask

    task automatic test_random_modes();
        int dwell;
        do_reset(HALT);
        for (int s = 0; s < 40; s++) begin
            bus_a.iMode = 2'($urandom_range(0, 3));
            if (bus_a.iMode == RTB) bus_a.iBreakPC = m_pc + 32'(4 * $urandom_range(0, 3));
            dwell = $urandom_range(1, 14);
            for (int i = 0; i < dwell; i++) begin
                adv();
                checks++;
                if (bus_a.oCpuClk !== m_clk || bus_a.oCycleCnt !== m_cnt || bus_a.oState !== m_state_f() || bus_a.oHalted !== m_brk) begin
                    failures++;
                    $display("FAIL rand_seg%0d_cyc%0d got clk=%b cnt=%0d st=%0d h=%b want clk=%b cnt=%0d st=%0d h=%b", s, i,
                             bus_a.oCpuClk, bus_a.oCycleCnt, bus_a.oState, bus_a.oHalted, m_clk, m_cnt, m_state_f(), m_brk);
                end
            end
        end
    endtask

    // Watchdog: the run is bounded even if something stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_run();
        test_step_debounce();
        test_back_to_back();
        test_breakpoint();
        test_halt_midcycle();
        test_wrap_reset();
        test_random_modes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
